// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM: opcodes,
// state/class enums, control-bundle field encodings and the bundle struct.
package ctrl_pkg;

  localparam int OPCODE_W = 7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_JAL
  } class_t;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_RFUNCT = 2'd2;
  localparam logic [1:0] ALUOP_IFUNCT = 2'd3;

  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_S = 3'd1;
  localparam logic [2:0] EXT_B = 3'd2;
  localparam logic [2:0] EXT_U = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_DM  = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;
  localparam logic [1:0] MTR_IMM = 2'd3;

  typedef struct packed {
    logic       aluSrc;
    logic [1:0] aluOp;
    logic [2:0] extenSel;
    logic [1:0] memToReg;
    logic       jump;
  } ctrl_bundle_t;

  function automatic ctrl_bundle_t makeBundle(input logic aluSrc, input logic [1:0] aluOp,
                                              input logic [2:0] extenSel,
                                              input logic [1:0] memToReg, input logic jump);
    ctrl_bundle_t b;
    b.aluSrc   = aluSrc;
    b.aluOp    = aluOp;
    b.extenSel = extenSel;
    b.memToReg = memToReg;
    b.jump     = jump;
    return b;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bus between IR/memories and the datapath; master is the
// controller, slave is the datapath/memory side.
interface multicycle_control_if
  import ctrl_pkg::*;
#(
  parameter int OP_W = OPCODE_W
);

  logic [OP_W-1:0] OP;
  logic            IM_ready;
  logic            DM_ready;
  logic            IR_write;
  logic            PC_write;
  logic            DM_en;
  logic            DM_write;
  logic            RegWrite;
  logic            branch;
  logic            jump;
  logic            ALUSrc;
  logic [1:0]      MemtoReg;
  logic [1:0]      ALUOp;
  logic [2:0]      ExtenSel;
  logic            trap;
  logic            trap_cause;
  logic [2:0]      state;

  modport master (
    input  OP, IM_ready, DM_ready,
    output IR_write, PC_write, DM_en, DM_write, RegWrite, branch, jump,
           ALUSrc, MemtoReg, ALUOp, ExtenSel, trap, trap_cause, state
  );

  modport slave (
    output OP, IM_ready, DM_ready,
    input  IR_write, PC_write, DM_en, DM_write, RegWrite, branch, jump,
           ALUSrc, MemtoReg, ALUOp, ExtenSel, trap, trap_cause, state
  );

endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier: maps an RV32I opcode to its instruction
// class and control bundle, flagging anything outside the supported subset.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] op,
  output class_t              opClass,
  output ctrl_bundle_t        bundle,
  output logic                illegal
);

  always_comb begin
    opClass = CLS_R;
    bundle  = '0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        opClass = CLS_R;
        bundle  = makeBundle(1'b0, ALUOP_RFUNCT, EXT_I, MTR_ALU, 1'b0);
      end
      OP_I: begin
        opClass = CLS_I;
        bundle  = makeBundle(1'b1, ALUOP_IFUNCT, EXT_I, MTR_ALU, 1'b0);
      end
      OP_LOAD: begin
        opClass = CLS_LOAD;
        bundle  = makeBundle(1'b1, ALUOP_ADD, EXT_I, MTR_DM, 1'b0);
      end
      OP_STORE: begin
        opClass = CLS_STORE;
        bundle  = makeBundle(1'b1, ALUOP_ADD, EXT_S, MTR_ALU, 1'b0);
      end
      OP_BRANCH: begin
        opClass = CLS_BRANCH;
        bundle  = makeBundle(1'b0, ALUOP_BRANCH, EXT_B, MTR_ALU, 1'b0);
      end
      OP_LUI: begin
        opClass = CLS_LUI;
        bundle  = makeBundle(1'b1, ALUOP_ADD, EXT_U, MTR_IMM, 1'b0);
      end
      OP_JAL: begin
        opClass = CLS_JAL;
        bundle  = makeBundle(1'b1, ALUOP_ADD, EXT_J, MTR_PC4, 1'b1);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with a bounded
// data-memory wait. Optional retire counter enabled by CTRL_RETIRE_CNT_EN.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 7,
  parameter int DM_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CTRL_RETIRE_CNT_EN
  output logic [CNT_W-1:0]     retire_cnt,
`endif
  multicycle_control_if.master bus
);

  localparam int WAIT_W = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'((DM_TIMEOUT > 0) ? DM_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (DM_TIMEOUT > 0);

  state_t            state, nextState;
  class_t            classReg, decClass;
  ctrl_bundle_t      bundleReg, decBundle;
  logic              decIllegal;
  logic [WAIT_W-1:0] waitCnt;
  logic              trapCause, trapCauseNext;
  logic              irWrite, pcWrite, dmEn, dmWrite, regWrite, branchPulse;
  logic [OP_W-1:0]   opcode;
  logic              bundleActive;

  assign opcode = bus.OP;

  ctrl_decode uDecode (
    .op      (opcode),
    .opClass (decClass),
    .bundle  (decBundle),
    .illegal (decIllegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  // Strobes are suppressed while rst is high so nothing is written on the way into reset.
  always_comb begin
    nextState     = state;
    trapCauseNext = trapCause;
    irWrite       = 1'b0;
    pcWrite       = 1'b0;
    dmEn          = 1'b0;
    dmWrite       = 1'b0;
    regWrite      = 1'b0;
    branchPulse   = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          if (bus.IM_ready) begin
            irWrite   = 1'b1;
            nextState = DECODE;
          end
        end
        DECODE: begin
          if (decIllegal) begin
            nextState     = TRAP;
            trapCauseNext = 1'b0;
          end else begin
            nextState = EXEC;
          end
        end
        EXEC: begin
          case (classReg)
            CLS_BRANCH: begin
              branchPulse = 1'b1;
              pcWrite     = 1'b1;
              nextState   = FETCH;
            end
            CLS_LOAD, CLS_STORE: nextState = MEM;
            default:             nextState = WB;
          endcase
        end
        MEM: begin
          dmEn    = 1'b1;
          dmWrite = (classReg == CLS_STORE);
          if (bus.DM_ready) begin
            if (classReg == CLS_STORE) begin
              pcWrite   = 1'b1;
              nextState = FETCH;
            end else begin
              nextState = WB;
            end
          end else if (TIMEOUT_EN && (waitCnt == TIMEOUT_LAST)) begin
            nextState     = TRAP;
            trapCauseNext = 1'b1;
          end
        end
        WB: begin
          regWrite  = 1'b1;
          pcWrite   = 1'b1;
          nextState = FETCH;
        end
        TRAP:    nextState = TRAP;
        default: nextState = FETCH;
      endcase
    end
  end

  // Class and bundle are captured once at DECODE exit and held until the next fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      classReg  <= CLS_R;
      bundleReg <= '0;
      waitCnt   <= '0;
      trapCause <= 1'b0;
    end else begin
      trapCause <= trapCauseNext;
      if (state == DECODE && !decIllegal) begin
        classReg  <= decClass;
        bundleReg <= decBundle;
      end
      if (state == MEM && nextState == MEM) waitCnt <= waitCnt + WAIT_W'(1);
      else                                  waitCnt <= '0;
    end
  end

  assign bundleActive = (state == EXEC) || (state == MEM) || (state == WB);

  assign bus.IR_write   = irWrite;
  assign bus.PC_write   = pcWrite;
  assign bus.DM_en      = dmEn;
  assign bus.DM_write   = dmWrite;
  assign bus.RegWrite   = regWrite;
  assign bus.branch     = branchPulse;
  assign bus.jump       = bundleActive & bundleReg.jump;
  assign bus.ALUSrc     = bundleActive & bundleReg.aluSrc;
  assign bus.MemtoReg   = bundleActive ? bundleReg.memToReg : 2'd0;
  assign bus.ALUOp      = bundleActive ? bundleReg.aluOp    : 2'd0;
  assign bus.ExtenSel   = bundleActive ? bundleReg.extenSel : 3'd0;
  assign bus.trap       = (state == TRAP);
  assign bus.trap_cause = trapCause;
  assign bus.state      = state;

`ifdef CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                            retire_cnt <= '0;
    else if (pcWrite && state != TRAP)  retire_cnt <= retire_cnt + CNT_W'(1);
  end
`else
  logic [CNT_W-1:0] unusedRetireCnt;
  assign unusedRetireCnt = '0;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, with wait states on instruction and data memory ready.
- Adds PC/IR write strobes, a sticky illegal-opcode/timeout trap, and a bounded data-memory wait.
- Sits between the instruction register and the datapath; drives the same control bundle the single-cycle decoder drives.

Parameters:
- OP_W, 7, opcode width; must be 7 for RV32I.
- DM_TIMEOUT, 16, max MEM wait cycles before trap; 0 disables timeout.
- CNT_W, 32, retire counter width (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- OP  in  OP_W  opcode from IR; valid from DECODE onward
- IM_ready  in  1  instruction memory data valid
- DM_ready  in  1  data memory access complete
- IR_write  out  1  load IR this cycle
- PC_write  out  1  update PC this cycle
- DM_en  out  1  data memory enable
- DM_write  out  1  data memory write
- RegWrite  out  1  register file write
- branch  out  1  branch resolve (PC_write gated by datapath compare)
- jump  out  1  JAL select
- ALUSrc  out  1  0=rs2, 1=immediate
- MemtoReg  out  2  0=ALU, 1=DM, 2=PC+4, 3=imm
- ALUOp  out  2  0=add, 1=branch compare, 2=R funct, 3=I funct
- ExtenSel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- trap  out  1  sticky error flag
- trap_cause  out  1  0=illegal opcode, 1=DM timeout
- state  out  3  current FSM state, for debug

Behaviour:
- Reset: state=FETCH; all outputs 0; wait counter 0. rst wins over every event, including mid-MEM.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: hold until IM_ready=1. IR_write=1 only in the IM_ready cycle, then go to DECODE.
- DECODE: classify OP as R, I, LOAD, STORE, BRANCH, LUI or JAL, and register the class. Any other OP -> TRAP with cause 0.
- The control bundle is registered at DECODE exit and held constant through EXEC/MEM/WB. It is 0 in FETCH, DECODE and TRAP.
- Bundle per class as ALUSrc/ALUOp/ExtenSel/MemtoReg:
  - R: 0/2/0/0
  - I: 1/3/0/0
  - LOAD: 1/0/0/1
  - STORE: 1/0/1/0
  - BRANCH: 0/1/2/0
  - LUI: 1/0/3/3
  - JAL: 1/0/4/2, jump=1
- EXEC transitions:
  - R, I, LUI, JAL -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: branch=1 and PC_write=1 for that cycle -> FETCH.
- MEM:
  - DM_en=1 every MEM cycle; DM_write=1 for STORE.
  - On DM_ready: LOAD -> WB; STORE -> FETCH with PC_write=1 that cycle.
  - Wait counter increments per MEM cycle without DM_ready. If it reaches DM_TIMEOUT (when nonzero) -> TRAP with cause 1.
  - Counter clears on MEM exit. DM_ready in the same cycle the counter reaches DM_TIMEOUT counts as success.
- WB: RegWrite=1 and PC_write=1 for one cycle -> FETCH.
- TRAP: absorbing until rst; trap=1, no strobes.
- Latencies with zero wait states:
  - R, I, LUI, JAL: 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Optional Feature:
- Macro CTRL_RETIRE_CNT_EN.
- Defined: extra output retire_cnt [CNT_W-1:0]. It increments on every PC_write cycle, wraps to 0 at all-ones, resets to 0, and freezes in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111, OP_JAL=1101111);
  - the state_t enum;
  - the class_t enum;
  - the ALUOp, ExtenSel and MemtoReg encodings;
  - a ctrl_bundle_t struct.
- One sub-module, ctrl_decode: combinational OP -> {class, bundle, illegal}, reused by the FSM.

Test Plan:
- Reset/R-type: rst high 2 cycles, then OP=0110011, IM_ready=1 -> IR_write at cycle 1, RegWrite=1 and PC_write=1 at cycle 4, ALUOp=2, state back to 0 at cycle 5.
- Load with wait: OP=0000011, DM_ready asserted after 3 MEM cycles -> DM_en high 4 cycles, MemtoReg=1, RegWrite in the following cycle.
- Store timeout: DM_TIMEOUT=16, OP=0100011, DM_ready never set -> DM_write held 16 cycles, then trap=1, trap_cause=1, state=5 until rst.
- Illegal: OP=1111111 -> trap=1, trap_cause=0 in the cycle after DECODE, no RegWrite/PC_write.
- Branch/JAL: OP=1100011 -> branch=1 and PC_write=1 at cycle 3, ExtenSel=2. OP=1101111 -> jump=1, MemtoReg=2, ExtenSel=4, RegWrite at cycle 4.
- Mid-op reset and counter: rst during MEM -> all outputs 0 next cycle. With CTRL_RETIRE_CNT_EN and 5 retired R-types -> retire_cnt=5.
